// File: rtl/uart_tx.sv
// UART transmitter: accepts a W_IN-bit word through a valid/ready handshake and
// sends it as NUM_WORDS back-to-back 8N1-style frames, least-significant frame first.
module uart_tx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_IN             = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W_IN-1:0] s_data,
    output logic            tx,
    output logic            busy
);

    localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
    localparam int PCNT_W    = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BCNT_W    = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BITS_PER_WORD - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        END
    } state_t;

    state_t            state;
    logic [PCNT_W-1:0] pcnt;
    logic [BCNT_W-1:0] bcnt;
    logic [WCNT_W-1:0] wcnt;
    logic [W_IN-1:0]   shreg;
    logic [W_IN-1:0]   shreg_next;
    logic              pulse_done;

    assign shreg_next = shreg >> 1;
    assign pulse_done = (pcnt == PCNT_LAST);

    // tx is loaded one cycle ahead of each state change so the line never glitches
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            pcnt    <= '0;
            bcnt    <= '0;
            wcnt    <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            s_ready <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pcnt    <= '0;
                    bcnt    <= '0;
                    wcnt    <= '0;
                    tx      <= 1'b1;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    if (s_valid && s_ready) begin
                        shreg   <= s_data;
                        state   <= START;
                        tx      <= 1'b0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (pulse_done) begin
                        pcnt  <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                DATA: begin
                    if (pulse_done) begin
                        pcnt  <= '0;
                        shreg <= shreg_next;
                        if (bcnt == BCNT_LAST) begin
                            bcnt  <= '0;
                            state <= END;
                            tx    <= 1'b1;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                            tx   <= shreg_next[0];
                        end
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                END: begin
                    if (pulse_done) begin
                        pcnt <= '0;
                        // Remaining frames of the same word follow with no idle gap
                        if (wcnt < WCNT_LAST) begin
                            wcnt  <= wcnt + 1'b1;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            wcnt    <= '0;
                            state   <= IDLE;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveforms are built from the frame
// format, and a sampling receiver model decodes tx back into words.
module tb_uart_tx;

    localparam int CPP       = 4;
    localparam int FRAME_CYC = 10 * CPP;

    logic        clk;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        tx;
    logic        busy;

    logic        s_valid8;
    logic        s_ready8;
    logic [7:0]  s_data8;
    logic        tx8;
    logic        busy8;

    int total = 0;
    int bad   = 0;

    bit exp_wave[$];
    bit rx_wave[$];

    uart_tx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_IN(16)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .tx(tx), .busy(busy)
    );

    uart_tx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_IN(8)) dut8 (
        .clk(clk), .rstn(rstn), .s_valid(s_valid8), .s_ready(s_ready8),
        .s_data(s_data8), .tx(tx8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One entry per clock cycle: start bit, data LSB first, stop bit, per frame
    function automatic void buildWave(input logic [15:0] word, input int nwords);
        exp_wave.delete();
        for (int f = 0; f < nwords; f++) begin
            for (int k = 0; k < CPP; k++) exp_wave.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int k = 0; k < CPP; k++) exp_wave.push_back(word[f*8+b]);
            for (int k = 0; k < CPP; k++) exp_wave.push_back(1'b1);
        end
    endfunction

    function automatic logic [15:0] decodeRx(input int nwords);
        logic [15:0] w;
        w = '0;
        for (int f = 0; f < nwords; f++)
            for (int b = 0; b < 8; b++)
                w[f*8+b] = rx_wave[f*FRAME_CYC + (1+b)*CPP + CPP/2];
        return w;
    endfunction

    task automatic applyStimulus(input logic [15:0] word, input bit keep_valid,
                                 input logic [15:0] next_data, input int change_at);
        buildWave(word, 2);
        rx_wave.delete();
        checkOutput("ready_pre", {15'b0, s_ready}, 16'd1);
        s_valid = 1'b1;
        s_data  = word;
        @(negedge clk);
        s_valid = keep_valid;
        for (int c = 0; c < exp_wave.size(); c++) begin
            if (c == change_at) s_data = next_data;
            checkOutput($sformatf("tx w=%h c=%0d", word, c), {15'b0, tx}, {15'b0, exp_wave[c]});
            checkOutput($sformatf("ready_busy w=%h c=%0d", word, c), {14'b0, s_ready, busy}, 16'b01);
            rx_wave.push_back(tx);
            @(negedge clk);
        end
        checkOutput("ready_post", {15'b0, s_ready}, 16'd1);
        checkOutput("busy_post", {15'b0, busy}, 16'd0);
        checkOutput("tx_gap", {15'b0, tx}, 16'd1);
        for (int f = 0; f < 2; f++) begin
            checkOutput("rx_start", {15'b0, rx_wave[f*FRAME_CYC + CPP/2]}, 16'd0);
            checkOutput("rx_stop", {15'b0, rx_wave[f*FRAME_CYC + 9*CPP + CPP/2]}, 16'd1);
        end
        checkOutput("rx_word", decodeRx(2), word);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] nxt;

        rstn     = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_valid8 = 1'b0;
        s_data8  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_tx", {15'b0, tx}, 16'd1);
        checkOutput("rst_ready", {15'b0, s_ready}, 16'd0);
        checkOutput("rst_busy", {15'b0, busy}, 16'd0);
        checkOutput("rst_tx8", {15'b0, tx8}, 16'd1);
        checkOutput("rst_ready8", {15'b0, s_ready8}, 16'd0);
        checkOutput("rst_busy8", {15'b0, busy8}, 16'd0);

        rstn = 1'b1;
        #1;
        checkOutput("release_ready", {15'b0, s_ready}, 16'd0);
        @(negedge clk);
        checkOutput("first_edge_ready", {15'b0, s_ready}, 16'd1);
        checkOutput("first_edge_ready8", {15'b0, s_ready8}, 16'd1);
        checkOutput("first_edge_busy", {15'b0, busy}, 16'd0);

        $display("[TB] single word A53C");
        applyStimulus(16'hA53C, 1'b0, 16'hA53C, 0);
        @(negedge clk);

        $display("[TB] back-to-back 00FF then FFFF");
        applyStimulus(16'h00FF, 1'b1, 16'hFFFF, 0);
        applyStimulus(16'hFFFF, 1'b0, 16'hFFFF, 0);
        @(negedge clk);

        $display("[TB] data change mid-transmission");
        applyStimulus(16'h5678, 1'b0, 16'h1234, 40);
        s_data = '0;
        @(negedge clk);

        $display("[TB] reset during bit 3 of frame 0");
        buildWave(16'h12A5, 2);
        s_valid = 1'b1;
        s_data  = 16'h12A5;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (17) @(negedge clk);
        checkOutput("pre_abort_tx", {15'b0, tx}, {15'b0, exp_wave[17]});
        rstn = 1'b0;
        #1;
        checkOutput("abort_tx", {15'b0, tx}, 16'd1);
        checkOutput("abort_ready", {15'b0, s_ready}, 16'd0);
        checkOutput("abort_busy", {15'b0, busy}, 16'd0);
        @(negedge clk);
        checkOutput("abort_hold_tx", {15'b0, tx}, 16'd1);
        rstn = 1'b1;
        #1;
        checkOutput("abort_release_ready", {15'b0, s_ready}, 16'd0);
        @(negedge clk);
        checkOutput("abort_next_ready", {15'b0, s_ready}, 16'd1);
        checkOutput("abort_next_tx", {15'b0, tx}, 16'd1);
        applyStimulus(16'h0001, 1'b0, 16'h0001, 0);

        $display("[TB] loopback of 100 random words");
        w = 16'($urandom);
        for (int i = 0; i < 100; i++) begin
            nxt = 16'($urandom);
            applyStimulus(w, (i < 99), nxt, 0);
            w = nxt;
        end

        // Idle line must ignore s_data while s_valid is low
        for (int i = 0; i < 6; i++) begin
            s_data = 16'($urandom);
            @(negedge clk);
            checkOutput("idle_tx", {15'b0, tx}, 16'd1);
            checkOutput("idle_ready", {15'b0, s_ready}, 16'd1);
        end

        $display("[TB] single-frame instance sends 80");
        buildWave(16'h0080, 1);
        s_valid8 = 1'b1;
        s_data8  = 8'h80;
        @(negedge clk);
        s_valid8 = 1'b0;
        for (int c = 0; c < exp_wave.size(); c++) begin
            checkOutput($sformatf("tx8 c=%0d", c), {15'b0, tx8}, {15'b0, exp_wave[c]});
            checkOutput($sformatf("ready_busy8 c=%0d", c), {14'b0, s_ready8, busy8}, 16'b01);
            @(negedge clk);
        end
        checkOutput("ready8_post", {15'b0, s_ready8}, 16'd1);
        checkOutput("busy8_post", {15'b0, busy8}, 16'd0);
        checkOutput("tx8_post", {15'b0, tx8}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
